meatsquare_drawer: RTL and testbench

- Sprite stage for one falling "meatsquare". Runs in parallel with the sky drawer and feeds the same VGA pixel port (x, y, colour, plot) through the top-level plot mux.
- On each frame request from the game controller it does three things in order:
  - erases the square at its old position (draws black);
  - moves it down;
  - redraws it in colour.
- Pulses finish_drawing when the frame update is complete.
- When the square passes the bottom of the 160x120 screen, it respawns at the top at a pseudo-random column and pulses hit_ground.

---
 rtl/meatsquare_drawer.sv | 136 +++++++++++++
 tb/tb_meatsquare_drawer.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/meatsquare_drawer.sv
// Falling-square sprite: erases the square, steps it down one frame, redraws it.
// When it would pass the bottom edge it respawns at the top, at a column taken from a free-running LFSR.
module meatsquare_drawer #(
  parameter int          SIZE     = 4,
  parameter int          STEP     = 1,
  parameter logic [2:0]  COLOUR   = 3'b100,
  parameter int          SCREEN_W = 160,
  parameter int          SCREEN_H = 120,
  parameter logic [7:0]  SEED     = 8'hA5
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       go,
  output logic [7:0] x,
  output logic [6:0] y,
  output logic [2:0] color,
  output logic       plot,
  output logic       finish_drawing,
  output logic       hit_ground
);

  localparam int NPIX = SIZE * SIZE;
  localparam int CW   = (NPIX > 1) ? $clog2(NPIX) : 1;
  localparam logic [CW-1:0] LAST = CW'(NPIX - 1);

  typedef enum logic [2:0] {IDLE, ERASE, MOVE, DRAW, DONE} state_t;

  // Columns at or past the last fully visible start column fold back onto the left of the screen.
  function automatic logic [7:0] map_col(input logic [7:0] v);
    if (v >= 8'(SCREEN_W - SIZE))
      return v - 8'(SCREEN_W - SIZE);
    else
      return v;
  endfunction

  state_t        state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [7:0]    pos_x, pos_x_n;
  logic [6:0]    pos_y, pos_y_n;
  logic          respawn, respawn_n;
  logic [7:0]    lfsr;
  logic [7:0]    x_n;
  logic [6:0]    y_n;
  logic [2:0]    color_n;
  logic          plot_n, finish_n, hit_n;
  logic [7:0]    col;
  logic [6:0]    row;
  logic [7:0]    ny;

  assign col = 8'(cnt % CW'(SIZE));
  assign row = 7'(cnt / CW'(SIZE));
  // Eight bits so a step off the bottom row cannot wrap back to a small value.
  assign ny  = {1'b0, pos_y} + 8'(STEP);

  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    pos_x_n   = pos_x;
    pos_y_n   = pos_y;
    respawn_n = respawn;
    x_n       = '0;
    y_n       = '0;
    color_n   = '0;
    plot_n    = 1'b0;
    finish_n  = 1'b0;
    hit_n     = 1'b0;
    case (state)
      IDLE: begin
        if (go) begin
          state_n = ERASE;
          cnt_n   = '0;
        end
      end
      ERASE, DRAW: begin
        plot_n  = 1'b1;
        x_n     = pos_x + col;
        y_n     = pos_y + row;
        color_n = (state == DRAW) ? COLOUR : 3'b000;
        if (cnt == LAST)
          state_n = (state == ERASE) ? MOVE : DONE;
        else
          cnt_n = cnt + 1'b1;
      end
      MOVE: begin
        if (({1'b0, ny} + 9'(SIZE)) > 9'(SCREEN_H)) begin
          pos_y_n   = '0;
          pos_x_n   = map_col(lfsr);
          respawn_n = 1'b1;
        end else begin
          pos_y_n = ny[6:0];
        end
        cnt_n   = '0;
        state_n = DRAW;
      end
      DONE: begin
        finish_n  = 1'b1;
        hit_n     = respawn;
        respawn_n = 1'b0;
        state_n   = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state          <= IDLE;
      cnt            <= '0;
      pos_x          <= map_col(SEED);
      pos_y          <= '0;
      respawn        <= 1'b0;
      lfsr           <= SEED;
      x              <= '0;
      y              <= '0;
      color          <= '0;
      plot           <= 1'b0;
      finish_drawing <= 1'b0;
      hit_ground     <= 1'b0;
    end else begin
      state          <= state_n;
      cnt            <= cnt_n;
      pos_x          <= pos_x_n;
      pos_y          <= pos_y_n;
      respawn        <= respawn_n;
      // Taps 8,6,5,4: maximal length, so the all-zero state is never entered.
      lfsr           <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
      x              <= x_n;
      y              <= y_n;
      color          <= color_n;
      plot           <= plot_n;
      finish_drawing <= finish_n;
      hit_ground     <= hit_n;
    end
  end

endmodule

// File: tb/tb_meatsquare_drawer.sv
// Randomised frame sequencing for meatsquare_drawer, checked cycle by cycle against a
// position/pixel reference model of the square's motion.
module tb_meatsquare_drawer;

  localparam int         SIZE     = 4;
  localparam int         SCREEN_W = 160;
  localparam int         SCREEN_H = 120;
  localparam logic [7:0] SEED     = 8'hA5;
  localparam logic [2:0] COLOUR   = 3'b100;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       go    = 1'b0;
  logic [7:0] x;
  logic [6:0] y;
  logic [2:0] color;
  logic       plot, finish_drawing, hit_ground;

  meatsquare_drawer dut (
    .clock(clock), .reset(reset), .go(go), .x(x), .y(y), .color(color),
    .plot(plot), .finish_drawing(finish_drawing), .hit_ground(hit_ground)
  );

  always #10 clock = ~clock;

  int n_cmp  = 0;
  int n_bad  = 0;
  int px, py;
  int fno    = 0;
  int n_resp = 0;
  bit prev_hold = 1'b0;

  // Reference LFSR, plus the value it held one clock earlier.
  logic [7:0] m_lfsr, m_prev;
  always @(posedge clock) begin
    m_prev <= m_lfsr;
    if (!reset) m_lfsr <= SEED;
    else        m_lfsr <= {m_lfsr[6:0], m_lfsr[7] ^ m_lfsr[5] ^ m_lfsr[4] ^ m_lfsr[3]};
  end

  function automatic int map_col(int v);
    return (v >= SCREEN_W - SIZE) ? v - (SCREEN_W - SIZE) : v;
  endfunction

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Pixel fields only matter while plot is expected high.
  task automatic expect_out(string tag, bit eplot, int ex, int ey, logic [2:0] ec, bit efin, bit ehit);
    logic [20:0] o, e;
    if (eplot) begin
      o = {plot, x, y, color, finish_drawing, hit_ground};
      e = {1'b1, 8'(ex), 7'(ey), ec, efin, ehit};
    end else begin
      o = {18'd0, plot, finish_drawing, hit_ground};
      e = {18'd0, 1'b0, efin, ehit};
    end
    chk(tag, 32'(o), 32'(e));
  endtask

  task automatic frame(bit hold, bit noise);
    int  ox, oy, nx, ny, idx;
    bit  resp;
    string tag;
    ox = px; oy = py; nx = px; ny = py; resp = 1'b0;
    fno++;
    go = 1'b1;
    @(posedge clock);
    @(negedge clock);
    go = hold;
    for (int k = 1; k <= 34; k++) begin
      @(negedge clock);
      tag = $sformatf("f%0d_k%0d", fno, k);
      if (k <= 16) begin
        idx = k - 1;
        expect_out(tag, 1'b1, ox + idx % SIZE, oy + idx / SIZE, 3'b000, 1'b0, 1'b0);
      end else if (k == 17) begin
        if (oy + 1 + SIZE > SCREEN_H) begin
          resp = 1'b1;
          nx   = map_col(int'(m_prev));
          ny   = 0;
        end else begin
          nx = ox;
          ny = oy + 1;
        end
        expect_out(tag, 1'b0, 0, 0, 3'b000, 1'b0, 1'b0);
      end else if (k <= 33) begin
        idx = k - 18;
        expect_out(tag, 1'b1, nx + idx % SIZE, ny + idx / SIZE, COLOUR, 1'b0, 1'b0);
        if (k == 18 && resp)
          chk($sformatf("f%0d_respawn_x_range", fno), 32'(x <= 8'd155), 32'd1);
      end else begin
        expect_out(tag, 1'b0, 0, 0, 3'b000, 1'b1, resp);
      end
      go = hold || (noise && (k == 5 || k == 22));
    end
    px = nx; py = ny;
    if (resp) n_resp++;
    prev_hold = hold;
  endtask

  task automatic idle_cycles(string tag, int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clock);
      expect_out($sformatf("%s_%0d", tag, i), 1'b0, 0, 0, 3'b000, 1'b0, 1'b0);
    end
  endtask

  initial begin
    int gap;
    bit hold, noise;
    reset = 1'b0;
    go    = 1'b0;
    repeat (2) @(negedge clock);
    chk("reset_outputs", 32'({x, y, color, plot, finish_drawing, hit_ground}), 32'd0);
    reset = 1'b1;
    px = 9; py = 0;
    idle_cycles("post_reset_idle", 2);

    // First frame: erase at (9,0), draw at (9,1).
    frame(1'b0, 1'b0);
    idle_cycles("after_first", 2);
    frame(1'b0, 1'b1);

    // Random mix of gaps, held go and spurious go pulses until two respawns.
    while (n_resp < 2 && fno < 300) begin
      if (!prev_hold) begin
        gap = $urandom_range(0, 3);
        idle_cycles($sformatf("gap%0d", fno), gap);
      end
      hold  = ($urandom_range(0, 3) == 0);
      noise = ($urandom_range(0, 2) == 0);
      frame(hold, noise);
    end
    go = 1'b0;
    chk("two_respawns_seen", 32'(n_resp), 32'd2);
    idle_cycles("drain", 2);

    // Reset on the fifth erase cycle aborts the pass.
    go = 1'b1;
    @(posedge clock);
    @(negedge clock);
    go = 1'b0;
    repeat (4) @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    chk("abort_outputs", 32'({x, y, color, plot, finish_drawing, hit_ground}), 32'd0);
    @(negedge clock);
    reset = 1'b1;
    idle_cycles("abort_idle", 40);
    px = 9; py = 0;
    frame(1'b0, 1'b0);
    idle_cycles("final_idle", 2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
